// File: rtl/ltsm_sb_hs_engine.sv
// Sideband REQ/RESP handshake for one LTSM state: local and partner exchanges share one TX slot.
// Valid rises 1 cycle after a send state is entered; a grant is held until i_SB_Busy falls.
module ltsm_sb_hs_engine #(
  parameter int                      SB_MSG_WIDTH   = 4,
  parameter logic [SB_MSG_WIDTH-1:0] REQ_CODE       = 4'd1,
  parameter logic [SB_MSG_WIDTH-1:0] RESP_CODE      = 4'd2,
  parameter int                      TIMEOUT_W      = 20,
  parameter int                      TIMEOUT_CYCLES = 800000,
  parameter int                      RESEND_CYCLES  = 100000,
  parameter int                      MAX_RESEND     = 3
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_hs_en,
  input  logic                    i_SB_Busy,
  input  logic                    i_rx_msg_valid,
  input  logic [SB_MSG_WIDTH-1:0] i_decoded_SB_msg,
  output logic [SB_MSG_WIDTH-1:0] o_encoded_SB_msg,
  output logic                    o_tx_msg_valid,
  output logic                    o_hs_end,
  output logic                    o_timeout
);

  localparam int RS_W = (RESEND_CYCLES > 1) ? $clog2(RESEND_CYCLES) : 1;
  localparam int RC_W = (MAX_RESEND > 0) ? $clog2(MAX_RESEND + 1) : 1;

  typedef enum logic [1:0] {TX_IDLE, TX_SEND_REQ, TX_WAIT_RESP, TX_DONE} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_WAIT_REQ, RX_SEND_RESP, RX_DONE} rx_state_e;
  typedef enum logic [1:0] {GNT_NONE, GNT_TX, GNT_RX} gnt_e;

  tx_state_e               tx_state_q, tx_state_d;
  rx_state_e               rx_state_q, rx_state_d;
  gnt_e                    grant_q, grant_d;
  logic                    busy_q;
  logic                    resp_seen_q, resp_seen_d;
  logic [RS_W-1:0]         rs_tmr_q, rs_tmr_d;
  logic [RC_W-1:0]         rs_cnt_q, rs_cnt_d;
  logic [TIMEOUT_W-1:0]    tmo_cnt_q, tmo_cnt_d;
  logic                    timeout_q, timeout_d;
  logic                    hs_end_q, hs_end_d;
  logic                    tx_vld_q, tx_vld_d;
  logic [SB_MSG_WIDTH-1:0] msg_q, msg_d;

  logic sent_evt, tx_sent, rx_sent, rx_req_hit, rx_resp_hit, tmo_hit;

  assign sent_evt    = busy_q & ~i_SB_Busy;
  assign tx_sent     = sent_evt && (grant_q == GNT_TX);
  assign rx_sent     = sent_evt && (grant_q == GNT_RX);
  assign rx_req_hit  = i_rx_msg_valid && (i_decoded_SB_msg == REQ_CODE);
  assign rx_resp_hit = i_rx_msg_valid && (i_decoded_SB_msg == RESP_CODE);
  assign tmo_hit     = i_hs_en && !timeout_q && !hs_end_q &&
                       (tmo_cnt_q == TIMEOUT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    tx_state_d  = tx_state_q;
    rx_state_d  = rx_state_q;
    grant_d     = grant_q;
    resp_seen_d = resp_seen_q;
    rs_tmr_d    = rs_tmr_q;
    rs_cnt_d    = rs_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    timeout_d   = timeout_q;
    hs_end_d    = hs_end_q;

    if (!i_hs_en) begin
      tx_state_d  = TX_IDLE;
      rx_state_d  = RX_IDLE;
      grant_d     = GNT_NONE;
      resp_seen_d = 1'b0;
      rs_tmr_d    = '0;
      rs_cnt_d    = '0;
      tmo_cnt_d   = '0;
      timeout_d   = 1'b0;
      hs_end_d    = 1'b0;
    end else if (timeout_q) begin
      grant_d = GNT_NONE;
    end else if (tmo_hit) begin
      // Both exchanges freeze where they are; only the flag and the dropped grant change.
      timeout_d = 1'b1;
      grant_d   = GNT_NONE;
    end else begin
      if (!hs_end_q && !(&tmo_cnt_q)) tmo_cnt_d = tmo_cnt_q + 1'b1;
      hs_end_d = (tx_state_q == TX_DONE) && (rx_state_q == RX_DONE);

      if (grant_q == GNT_NONE) begin
        if (rx_state_q == RX_SEND_RESP)     grant_d = GNT_RX;
        else if (tx_state_q == TX_SEND_REQ) grant_d = GNT_TX;
      end else if (sent_evt) begin
        grant_d = GNT_NONE;
      end

      unique case (tx_state_q)
        TX_IDLE: begin
          tx_state_d  = TX_SEND_REQ;
          resp_seen_d = rx_resp_hit;
          rs_tmr_d    = '0;
          rs_cnt_d    = '0;
        end
        TX_SEND_REQ: begin
          // A RESP overtaking our own REQ is remembered and completes the exchange once the REQ leaves.
          if (rx_resp_hit) resp_seen_d = 1'b1;
          if (tx_sent) begin
            if (resp_seen_q || rx_resp_hit) begin
              tx_state_d = TX_DONE;
            end else begin
              tx_state_d = TX_WAIT_RESP;
              rs_tmr_d   = '0;
            end
          end
        end
        TX_WAIT_RESP: begin
          if (rx_resp_hit) begin
            tx_state_d = TX_DONE;
          end else if (rs_tmr_q == RS_W'(RESEND_CYCLES - 1)) begin
            if (rs_cnt_q < RC_W'(MAX_RESEND)) begin
              tx_state_d = TX_SEND_REQ;
              rs_cnt_d   = rs_cnt_q + 1'b1;
            end
          end else begin
            rs_tmr_d = rs_tmr_q + 1'b1;
          end
        end
        TX_DONE: tx_state_d = TX_DONE;
        default: tx_state_d = TX_IDLE;
      endcase

      unique case (rx_state_q)
        RX_IDLE:      rx_state_d = rx_req_hit ? RX_SEND_RESP : RX_WAIT_REQ;
        RX_WAIT_REQ:  if (rx_req_hit) rx_state_d = RX_SEND_RESP;
        RX_SEND_RESP: if (rx_sent) rx_state_d = RX_DONE;
        RX_DONE:      rx_state_d = RX_DONE;
        default:      rx_state_d = RX_IDLE;
      endcase
    end

    tx_vld_d = (grant_d != GNT_NONE);
    msg_d    = '0;
    if (grant_d == GNT_TX)      msg_d = REQ_CODE;
    else if (grant_d == GNT_RX) msg_d = RESP_CODE;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tx_state_q  <= TX_IDLE;
      rx_state_q  <= RX_IDLE;
      grant_q     <= GNT_NONE;
      busy_q      <= 1'b0;
      resp_seen_q <= 1'b0;
      rs_tmr_q    <= '0;
      rs_cnt_q    <= '0;
      tmo_cnt_q   <= '0;
      timeout_q   <= 1'b0;
      hs_end_q    <= 1'b0;
      tx_vld_q    <= 1'b0;
      msg_q       <= '0;
    end else begin
      tx_state_q  <= tx_state_d;
      rx_state_q  <= rx_state_d;
      grant_q     <= grant_d;
      busy_q      <= i_SB_Busy;
      resp_seen_q <= resp_seen_d;
      rs_tmr_q    <= rs_tmr_d;
      rs_cnt_q    <= rs_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      timeout_q   <= timeout_d;
      hs_end_q    <= hs_end_d;
      tx_vld_q    <= tx_vld_d;
      msg_q       <= msg_d;
    end
  end

  assign o_tx_msg_valid   = tx_vld_q;
  assign o_encoded_SB_msg = msg_q;
  assign o_hs_end         = hs_end_q;
  assign o_timeout        = timeout_q;

endmodule

// File: doc/ltsm_sb_hs_engine.md
Name: ltsm_sb_hs_engine

Overview:
- Generic, parametrised sideband REQ/RESP handshake engine for any LTSM state: TRAINERROR, SBINIT-style exits, LINKINIT and similar.
- Runs a local-initiated request/response exchange and a partner-initiated request/response exchange in parallel.
- Arbitrates both onto one sideband TX slot and adds a timeout with bounded request retransmission.
- Sits between the LTSM top controller and the sideband encoder/decoder; one instance per state handshake.

Parameters:
- SB_MSG_WIDTH, 4, width of encoded/decoded sideband message codes.
- REQ_CODE, 4'd1, code sent/expected for the state request message.
- RESP_CODE, 4'd2, code sent/expected for the state response message.
- TIMEOUT_W, 20, width of the timeout counter.
- TIMEOUT_CYCLES, 800000, cycles from enable to timeout (8 ms at 100 MHz); must be >= 2.
- RESEND_CYCLES, 100000, cycles waiting for RESP before REQ is retransmitted.
- MAX_RESEND, 3, maximum REQ retransmissions (0 disables retransmission).

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_hs_en  in  1  handshake enable from LTSM; level, held high for the whole handshake
- i_SB_Busy  in  1  1 = sideband transmitting; falling edge = granted message sent
- i_rx_msg_valid  in  1  one-cycle strobe: i_decoded_SB_msg is a new partner message
- i_decoded_SB_msg  in  SB_MSG_WIDTH  decoded partner message code
- o_encoded_SB_msg  out  SB_MSG_WIDTH  code to send; 0 when o_tx_msg_valid low
- o_tx_msg_valid  out  1  request to sideband to send o_encoded_SB_msg
- o_hs_end  out  1  both exchanges complete; held while i_hs_en high
- o_timeout  out  1  sticky timeout flag; held while i_hs_en high

Behaviour:
- Clock and reset: single clock i_clk; reset asynchronous active-low on i_rst_n.
- Reset: all FSMs IDLE, counters 0, busy_q 0, grant none; all outputs 0.
- Sent event: busy_q & ~i_SB_Busy, with busy_q = i_SB_Busy registered.
- TX FSM:
  - IDLE -> SEND_REQ on i_hs_en.
  - SEND_REQ: tx_req high; on a sent event while granted -> WAIT_RESP, resend timer cleared.
  - WAIT_RESP: rx strobe with code RESP_CODE -> TX_DONE.
  - WAIT_RESP: resend timer reaching RESEND_CYCLES-1 with resend_cnt < MAX_RESEND -> SEND_REQ, resend_cnt+1.
  - WAIT_RESP: timer expiry with resend_cnt == MAX_RESEND -> stay, timer frozen.
- RX FSM:
  - IDLE -> WAIT_REQ on i_hs_en.
  - WAIT_REQ: rx strobe with code REQ_CODE -> SEND_RESP.
  - SEND_RESP: rx_req high; sent event while granted -> RX_DONE.
  - Duplicate REQ in SEND_RESP or RX_DONE: ignored. A retransmitted partner REQ in RX_DONE must not re-send RESP.
- RX message handling:
  - REQ_CODE and RESP_CODE strobes are consumed by their FSMs in the same cycle and may arrive back-to-back.
  - Unknown codes are ignored.
  - RESP arriving while TX is still in SEND_REQ is accepted: TX goes to TX_DONE after its REQ is sent.
- Arbitration:
  - Grant is registered.
  - Grant is taken only when no grant is held; RX wins if both request in the same cycle.
  - Grant is held until that source's sent event, and released in the same cycle as the sent event.
  - o_tx_msg_valid = grant held. o_encoded_SB_msg = REQ_CODE or RESP_CODE per grant, else 0.
  - First valid appears 1 cycle after the FSM enters its send state.
- Completion: o_hs_end rises the cycle after both TX_DONE and RX_DONE are true.
- Timeout:
  - Counter increments every cycle while i_hs_en and not o_hs_end.
  - At TIMEOUT_CYCLES-1, o_timeout is set; both FSMs freeze, pending grant is dropped, valid goes to 0.
  - o_hs_end and o_timeout are never both 1.
- i_hs_en low (any time, including mid-send): next cycle all FSMs IDLE, counters and grant cleared, outputs 0. Re-enable restarts cleanly.
- Counters saturate; they never wrap.

Test Plan:
- Normal exchange: en=1 → valid=1, msg=1 at cycle 1. Busy 1 for 3 cycles then 0 → valid=0. Partner REQ strobe → valid=1, msg=2. Busy pulse, then partner RESP → o_hs_end=1 the cycle after both DONE.
- Collision: partner REQ arrives the same cycle the local REQ becomes pending (REQ_CODE=1, RESP_CODE=2) → RX granted first, msg=2. After its falling busy edge → msg=1. o_hs_end only after RESP received.
- Retransmission: RESEND_CYCLES=10, MAX_RESEND=2, no RESP → REQ sent 3 times total, 10 cycles apart after each send. Late RESP then completes the handshake.
- Timeout: TIMEOUT_CYCLES=50, partner silent → o_timeout=1 at cycle 49 after enable, valid=0, o_hs_end stays 0. Deassert en → o_timeout=0 next cycle.
- Abort mid-send: drop en while busy=1 and valid=1 → all outputs 0 next cycle. Re-enable → fresh REQ after 1 cycle with resend_cnt 0.
- Noise and duplicates: unknown code 7 strobes and a duplicate REQ after RX_DONE → no extra RESP sent, state unchanged, o_hs_end timing unaffected.
